mcpu_alu_bist: RTL and testbench

Built-in self-test controller for the MCPU ALU. It drives `opcode`, `r1` and `r2` into an `MCPU_Alu` instance from a seeded LFSR and checks the ALU's `out` and `OVERFLOW` against an internal reference model. It counts mismatches and captures the first failing vector. It sits beside the ALU in the MCPU datapath and provides synthesizable, repeatable stimulus and checking in place of free-running random stimulus.

---
 rtl/mcpu_alu_bist.sv | 138 +++++++++++++
 tb/tb_mcpu_alu_bist.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_alu_bist.sv
// Built-in self-test controller for the MCPU ALU: LFSR-driven vectors, reference-model
// checking, mismatch count with saturation and capture of the first failing vector.
module mcpu_alu_bist #(
  parameter int          CMD_SIZE    = 2,
  parameter int          WORD_SIZE   = 2,
  parameter int          NUM_VECTORS = 64,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [CMD_SIZE-1:0]  opcode,
  output logic [WORD_SIZE-1:0] r1,
  output logic [WORD_SIZE-1:0] r2,
  input  logic [WORD_SIZE-1:0] alu_out,
  input  logic                 alu_overflow,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic [CMD_SIZE-1:0]  fail_opcode,
  output logic [WORD_SIZE-1:0] fail_r1,
  output logic [WORD_SIZE-1:0] fail_r2,
  output logic [1:0]           dbg_state
);

  localparam int          VW       = 2*WORD_SIZE + CMD_SIZE;
  localparam int          MSB      = WORD_SIZE - 1;
  localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [15:0]            lfsr;
  logic [15:0]            lfsr_nxt;
  logic [15:0]            vec_cnt;
  logic                   launch;
  logic [1:0]             op_sel;
  logic [WORD_SIZE-1:0]   sum;
  logic [WORD_SIZE-1:0]   diff;
  logic [WORD_SIZE-1:0]   exp_out;
  logic                   exp_ovf;
  logic                   mismatch;

  // start/done handshake: start is only honoured in IDLE or DONE (a one-cycle pulse is
  // enough); done then stays high until the next accepted start or reset.
  assign launch   = start && (state == IDLE || state == DONE);
  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   state_nxt = CHECK;
      CHECK:   state_nxt = (vec_cnt == LAST_VEC) ? DONE : DRIVE;
      DONE:    if (start) state_nxt = DRIVE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == DRIVE) || (state == CHECK);
    done      = (state == DONE);
    pass      = (state == DONE) && (err_count == 16'd0);
    dbg_state = state;
  end

  // Reference ALU; only the low two opcode bits select the operation.
  assign op_sel = opcode[1:0];
  assign sum    = r1 + r2;
  assign diff   = r1 - r2;

  always_comb begin
    exp_out = '0;
    exp_ovf = 1'b0;
    case (op_sel)
      2'b00: exp_out = r1 & r2;
      2'b01: exp_out = r1 | r2;
      2'b10: begin
        exp_out = sum;
        exp_ovf = (r1[MSB] == r2[MSB]) && (sum[MSB] != r1[MSB]);
      end
      default: begin
        exp_out = diff;
        exp_ovf = (r1[MSB] != r2[MSB]) && (diff[MSB] != r1[MSB]);
      end
    endcase
    mismatch = (alu_out != exp_out) || (alu_overflow != exp_ovf);
  end

  // The vector registers are loaded at launch and at each CHECK edge, so they hold
  // steady across the DRIVE/CHECK pair of the vector they carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr        <= SEED;
      vec_cnt     <= 16'd0;
      opcode      <= '0;
      r1          <= '0;
      r2          <= '0;
      err_count   <= 16'd0;
      fail_opcode <= '0;
      fail_r1     <= '0;
      fail_r2     <= '0;
    end else if (launch) begin
      lfsr               <= SEED;
      vec_cnt            <= 16'd0;
      {r2, r1, opcode}   <= SEED[VW-1:0];
      err_count          <= 16'd0;
      fail_opcode        <= '0;
      fail_r1            <= '0;
      fail_r2            <= '0;
    end else if (state == CHECK) begin
      if (mismatch) begin
        if (err_count == 16'd0) begin
          fail_opcode <= opcode;
          fail_r1     <= r1;
          fail_r2     <= r2;
        end
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
      lfsr    <= lfsr_nxt;
      vec_cnt <= vec_cnt + 16'd1;
      if (vec_cnt != LAST_VEC) {r2, r1, opcode} <= lfsr_nxt[VW-1:0];
    end
  end

endmodule

// File: tb/tb_mcpu_alu_bist.sv
// Bench for mcpu_alu_bist: behavioural ALU with fault modes, hand-computed vector table,
// LFSR-based expected queue and end-of-run result checks.
module tb_mcpu_alu_bist;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  opcode;
  logic [1:0]  r1;
  logic [1:0]  r2;
  logic [1:0]  alu_out;
  logic        alu_overflow;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [1:0]  fail_opcode;
  logic [1:0]  fail_r1;
  logic [1:0]  fail_r2;
  logic [1:0]  dbg_state;

  int          checks;
  int          failures;
  int          fault_mode;
  logic [2:0]  alu_res;

  logic [5:0]  exp_q[$];
  int          exp_err;
  logic [5:0]  exp_fail;

  typedef struct {
    int         idx;
    logic [1:0] op;
    logic [1:0] a;
    logic [1:0] b;
  } vec_t;
  vec_t tbl[4];

  mcpu_alu_bist #(
    .CMD_SIZE(2), .WORD_SIZE(2), .NUM_VECTORS(64), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .opcode(opcode), .r1(r1), .r2(r2),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_opcode(fail_opcode), .fail_r1(fail_r1), .fail_r2(fail_r2),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ALU result as {overflow, out}, worked out on sign-extended integers.
  function automatic logic [2:0] ref_alu(input logic [1:0] op, input logic [1:0] a,
                                         input logic [1:0] b);
    int         sa;
    int         sb;
    int         t;
    logic [1:0] res;
    logic       ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    t   = 0;
    res = 2'b00;
    ovf = 1'b0;
    case (op)
      2'b00: res = a & b;
      2'b01: res = a | b;
      2'b10: begin t = sa + sb; res = t[1:0]; ovf = (t > 1) || (t < -2); end
      default: begin t = sa - sb; res = t[1:0]; ovf = (t > 1) || (t < -2); end
    endcase
    return {ovf, res};
  endfunction

  // ALU beside the DUT: 0 = healthy, 1 = out stuck at 00, 2 = overflow stuck at 1
  always_comb begin
    alu_res      = ref_alu(opcode, r1, r2);
    alu_out      = (fault_mode == 1) ? 2'b00 : alu_res[1:0];
    alu_overflow = (fault_mode == 2) ? 1'b1 : alu_res[2];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_opcode"}, 32'(opcode), 32'd0);
    chk({tag, "_r1"}, 32'(r1), 32'd0);
    chk({tag, "_r2"}, 32'(r2), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
    chk({tag, "_fail"}, 32'({fail_r2, fail_r1, fail_opcode}), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // expected vector sequence and expected error outcome for a fault mode
  task automatic build_model(input int mode);
    logic [15:0] l;
    logic [5:0]  v;
    logic [2:0]  r;
    logic        bad;
    exp_q.delete();
    exp_err  = 0;
    exp_fail = 6'd0;
    l = 16'hACE1;
    for (int k = 0; k < 64; k++) begin
      v = {l[5:4], l[3:2], l[1:0]};
      exp_q.push_back(v);
      r   = ref_alu(l[1:0], l[3:2], l[5:4]);
      bad = (mode == 1 && r[1:0] != 2'b00) || (mode == 2 && r[2] == 1'b0);
      if (bad) begin
        if (exp_err == 0) exp_fail = v;
        exp_err++;
      end
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
  endtask

  // One run; cycle numbers count from the start edge T (cycle 1 = T+1).
  task automatic run_vectors(input int mode, input int pulse_at, input int rst_at);
    int         cyc;
    int         k;
    logic [5:0] cur;
    logic [5:0] got;
    fault_mode = mode;
    build_model(mode);
    cur   = 6'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 200) begin
      got = {r2, r1, opcode};
      chk("busy_in_run", 32'(busy), 32'd1);
      if (cyc % 2 == 1) begin
        k = (cyc - 1) / 2;
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else cur = 6'bx;
        chk("drive_vector", 32'(got), 32'(cur));
        chk("drive_state", 32'(dbg_state), 32'd1);
        for (int i = 0; i < 4; i++)
          if (tbl[i].idx == k)
            chk("table_vector", 32'(got), 32'({tbl[i].b, tbl[i].a, tbl[i].op}));
      end else begin
        chk("check_stable", 32'(got), 32'(cur));
        chk("check_state", 32'(dbg_state), 32'd2);
      end
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_zero("midrun_rst");
        return;
      end
      start = (cyc == pulse_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_cycle", 32'(cyc), 32'd129);
    chk("done", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("done_state", 32'(dbg_state), 32'd3);
    chk("err_count", 32'(err_count), 32'(exp_err));
    chk("pass", 32'(pass), 32'(exp_err == 0));
    chk("fail_vector", 32'({fail_r2, fail_r1, fail_opcode}), 32'(exp_fail));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    fault_mode = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    // first four vectors from SEED 16'hACE1 and its successors 59C3, B387, 670F
    tbl[0] = '{idx: 0, op: 2'b01, a: 2'b00, b: 2'b10};
    tbl[1] = '{idx: 1, op: 2'b11, a: 2'b00, b: 2'b00};
    tbl[2] = '{idx: 2, op: 2'b11, a: 2'b01, b: 2'b00};
    tbl[3] = '{idx: 3, op: 2'b11, a: 2'b11, b: 2'b00};

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("idle");

    run_vectors(0, -1, -1);   // golden run from IDLE
    run_vectors(1, -1, -1);   // restart from DONE, out stuck at 00
    run_vectors(2, -1, -1);   // overflow stuck at 1
    run_vectors(0, 22, -1);   // start pulse during CHECK of vector 10
    run_vectors(0, -1, 40);   // reset mid-run
    repeat (2) @(negedge clk);
    check_zero("after_rst");
    run_vectors(0, -1, -1);   // rerun from SEED after reset

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
